multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_inst_classifier.sv | 31 +++
 rtl/multicycle_controller.sv | 144 ++++++++++++++
 tb/tb_multicycle_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, opcodes,
// mux-select encodings, the one-hot instruction class and the ALU op-code helper.
package multicycle_controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH     = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_EXECUTE   = 3'd2;
  localparam state_t ST_MEM       = 3'd3;
  localparam state_t ST_WRITEBACK = 3'd4;
  localparam state_t ST_MULWAIT   = 3'd5;
  localparam state_t ST_FAULT     = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_MEM = 2'd1;
  localparam logic [1:0] RD_PC4 = 2'd2;

  localparam logic [1:0] RS1_REG  = 2'd0;
  localparam logic [1:0] RS1_PC   = 2'd1;
  localparam logic [1:0] RS1_ZERO = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic mul;
  } cls_t;

  // inst[30] only selects SUB/SRA; for I-type it is meaningful only on shifts-right.
  function automatic logic [3:0] alu_code(input cls_t c, input logic [2:0] f3, input logic b30);
    if (c.r)      return {b30, f3};
    if (c.i)      return {(f3 == 3'b101) & b30, f3};
    if (c.branch) return {1'b1, f3};
    return 4'b0000;
  endfunction

endpackage

// File: rtl/multicycle_controller_inst_classifier.sv
// Combinational opcode/funct decode to a one-hot class; all-zero means illegal.
// MUL_EN enables the funct7=0000001 R-type encoding as class mul.
module inst_classifier
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output cls_t       o_cls
);

  logic w_mul_enc;
  assign w_mul_enc = (i_funct7 == F7_MUL);

  always_comb begin
    o_cls        = '0;
    o_cls.r      = (i_opcode == OP_R) && !w_mul_enc;
    o_cls.i      = (i_opcode == OP_I);
    o_cls.load   = (i_opcode == OP_LOAD);
    o_cls.store  = (i_opcode == OP_STORE);
    o_cls.branch = (i_opcode == OP_BRANCH) && (i_funct3[2:1] != 2'b01);
    o_cls.jal    = (i_opcode == OP_JAL);
    o_cls.jalr   = (i_opcode == OP_JALR) && (i_funct3 == 3'b000);
    o_cls.lui    = (i_opcode == OP_LUI);
    o_cls.auipc  = (i_opcode == OP_AUIPC);
`ifdef MUL_EN
    o_cls.mul    = (i_opcode == OP_R) && w_mul_enc;
`endif
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore multicycle controller; ALU op = 4 cycles at zero-wait memory, FETCH/MEM stall on mem_ack
// with a MEM_TIMEOUT fault. Optional macro MUL_EN adds the mul class and MULWAIT state.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_inst,
  input  logic                  i_mem_ack,
  input  logic                  i_br_taken,
  input  logic                  i_mul_done,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_mem_sel,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic                  o_reg_write,
  output logic [1:0]            o_pc_sel,
  output logic [ALU_CTRL_W-1:0] o_alu_controller,
  output logic [2:0]            o_imme_sel,
  output logic [1:0]            o_rd_sel,
  output logic [1:0]            o_rs1_sel,
  output logic                  o_mul_start,
  output logic                  o_fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  cls_t             r_cls, w_cls;
  logic [2:0]       r_funct3;
  logic             r_bit30;
  logic             w_fetch, w_exec, w_mem, w_wb, w_cnt_last, w_unused;
  logic [1:0]       w_pc_sel, w_rd_sel, w_rs1_sel;
  logic [2:0]       w_imme_sel;

  inst_classifier u_inst_classifier (
    .i_opcode (i_inst[6:0]),
    .i_funct3 (i_inst[14:12]),
    .i_funct7 (i_inst[31:25]),
    .o_cls    (w_cls)
  );

  assign w_fetch    = (r_state == ST_FETCH);
  assign w_exec     = (r_state == ST_EXECUTE);
  assign w_mem      = (r_state == ST_MEM);
  assign w_wb       = (r_state == ST_WRITEBACK);
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef MUL_EN
  assign w_unused = ^{i_inst[24:15], i_inst[11:7]};
`else
  assign w_unused = ^{i_inst[24:15], i_inst[11:7], i_mul_done};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:     if (i_mem_ack) w_next = ST_DECODE;
                    else if (w_cnt_last) w_next = ST_FAULT;
      ST_DECODE:    w_next = (w_cls == '0) ? ST_FAULT : ST_EXECUTE;
      ST_EXECUTE:   if (r_cls.load || r_cls.store) w_next = ST_MEM;
                    else if (r_cls.branch) w_next = ST_FETCH;
                    else if (r_cls.mul) w_next = ST_MULWAIT;
                    else w_next = ST_WRITEBACK;
      ST_MEM:       if (i_mem_ack) w_next = r_cls.load ? ST_WRITEBACK : ST_FETCH;
                    else if (w_cnt_last) w_next = ST_FAULT;
      ST_WRITEBACK: w_next = ST_FETCH;
`ifdef MUL_EN
      ST_MULWAIT:   if (i_mul_done) w_next = ST_WRITEBACK;
`else
      ST_MULWAIT:   w_next = ST_FAULT;
`endif
      default:      w_next = ST_FAULT;
    endcase
  end

  // Any state change restarts the wait counter, so it only runs while stalled in FETCH/MEM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_FETCH;
      r_cnt    <= '0;
      r_cls    <= '0;
      r_funct3 <= '0;
      r_bit30  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next)     r_cnt <= '0;
      else if (w_fetch || w_mem) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == ST_DECODE) begin
        r_cls    <= w_cls;
        r_funct3 <= i_inst[14:12];
        r_bit30  <= i_inst[30];
      end
    end
  end

  always_comb begin
    w_pc_sel = PC_PLUS4;
    if (w_exec && r_cls.branch)  w_pc_sel = PC_IMM;
    else if (w_wb && r_cls.jal)  w_pc_sel = PC_IMM;
    else if (w_wb && r_cls.jalr) w_pc_sel = PC_ALU;

    w_rd_sel = RD_ALU;
    if (r_cls.jal || r_cls.jalr) w_rd_sel = RD_PC4;
    else if (r_cls.load)         w_rd_sel = RD_MEM;

    w_rs1_sel = RS1_REG;
    if (r_cls.auipc || r_cls.jal || r_cls.branch) w_rs1_sel = RS1_PC;
    else if (r_cls.lui)                           w_rs1_sel = RS1_ZERO;

    w_imme_sel = IMM_I;
    if (r_cls.store)                  w_imme_sel = IMM_S;
    else if (r_cls.branch)            w_imme_sel = IMM_B;
    else if (r_cls.lui || r_cls.auipc) w_imme_sel = IMM_U;
    else if (r_cls.jal)               w_imme_sel = IMM_J;
  end

  // Gating with rst_n drops the FETCH request the instant reset asserts.
  assign o_mem_req        = i_rst_n & (w_fetch | w_mem);
  assign o_mem_sel        = i_rst_n & w_mem;
  assign o_mem_we         = i_rst_n & w_mem & r_cls.store;
  assign o_ir_write       = i_rst_n & w_fetch & i_mem_ack;
  assign o_pc_write       = i_rst_n & ((w_exec & r_cls.branch & i_br_taken)
                                     | (w_mem & r_cls.store & i_mem_ack) | w_wb);
  assign o_reg_write      = i_rst_n & w_wb;
  assign o_fault          = i_rst_n & (r_state == ST_FAULT);
`ifdef MUL_EN
  assign o_mul_start      = i_rst_n & w_exec & r_cls.mul;
`else
  assign o_mul_start      = 1'b0;
`endif
  assign o_pc_sel         = i_rst_n ? w_pc_sel   : '0;
  assign o_rd_sel         = i_rst_n ? w_rd_sel   : '0;
  assign o_rs1_sel        = i_rst_n ? w_rs1_sel  : '0;
  assign o_imme_sel       = i_rst_n ? w_imme_sel : '0;
  assign o_alu_controller = i_rst_n ? ALU_CTRL_W'(alu_code(r_cls, r_funct3, r_bit30)) : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller (MEM_TIMEOUT=4); follows MUL_EN if defined.
module tb_multicycle_controller;

  logic        clk, rst_n, mem_ack, br_taken, mul_done;
  logic [31:0] inst;
  logic        mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, mul_start, fault;
  logic [1:0]  pc_sel, rd_sel, rs1_sel;
  logic [2:0]  imme_sel;
  logic [3:0]  alu;
  logic [6:0]  strobes;
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SRAI = 32'h40315093;
  localparam logic [31:0] I_ADDI = 32'h40010093;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_MUL  = 32'h022080B3;

  multicycle_controller #(.MEM_TIMEOUT(4), .ALU_CTRL_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_mem_ack(mem_ack),
    .i_br_taken(br_taken), .i_mul_done(mul_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_sel(mem_sel),
    .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
    .o_pc_sel(pc_sel), .o_alu_controller(alu), .o_imme_sel(imme_sel),
    .o_rd_sel(rd_sel), .o_rs1_sel(rs1_sel), .o_mul_start(mul_start), .o_fault(fault)
  );

  // {mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, mul_start}
  assign strobes = {mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, mul_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called in a FETCH cycle: zero-wait fetch, returns in DECODE.
  task automatic fetch(input logic [31:0] ins, input string tag);
    inst = ins;
    mem_ack = 1'b1;
    #1 chk({tag, "_ir"}, 32'(strobes), 32'b1001000);
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inst = '0; mem_ack = 1'b0; br_taken = 1'b0; mul_done = 1'b0;
    #3;
    chk("rst_strobes", 32'(strobes), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_sels", 32'({pc_sel, imme_sel, rd_sel, rs1_sel, alu}), 32'd0);
    #4 rst_n = 1'b1;
    #1 chk("rel_fetch", 32'({mem_req, mem_sel}), 32'b10);

    // ADD, with mem_ack left high through DECODE/EXECUTE where it must be ignored
    inst = I_ADD; mem_ack = 1'b1;
    #1 chk("add_ir", 32'(strobes), 32'b1001000);
    tick(); #1 chk("add_dec", 32'(strobes), 32'd0);
    tick(); #1 chk("add_exe", 32'(strobes), 32'd0);
    tick(); mem_ack = 1'b0;
    #1 chk("add_wb", 32'(strobes), 32'b0000110);
    chk("add_wb_sel", 32'({alu, rd_sel, pc_sel}), 32'd0);
    tick(); #1 chk("add_next_fetch", 32'(strobes), 32'b1000000);

    // LW with data ack on the third MEM cycle
    fetch(I_LW, "lw");
    tick(); tick();
    #1 chk("lw_mem1", 32'(strobes), 32'b1010000);
    tick(); #1 chk("lw_mem2", 32'(strobes), 32'b1010000);
    tick(); mem_ack = 1'b1;
    #1 chk("lw_mem3", 32'(strobes), 32'b1010000);
    tick(); mem_ack = 1'b0;
    #1 chk("lw_wb", 32'(strobes), 32'b0000110);
    chk("lw_wb_sel", 32'({rd_sel, imme_sel}), 32'({2'd1, 3'd0}));
    tick();

    // BEQ taken then not taken
    fetch(I_BEQ, "beq_t");
    tick(); br_taken = 1'b1;
    #1 chk("beq_t_exe", 32'(strobes), 32'b0000100);
    chk("beq_t_sel", 32'({pc_sel, alu, imme_sel}), 32'({2'd1, 4'b1000, 3'd2}));
    tick(); br_taken = 1'b0;
    #1 chk("beq_t_fetch", 32'(strobes), 32'b1000000);
    fetch(I_BEQ, "beq_n");
    tick(); #1 chk("beq_n_exe", 32'(strobes), 32'd0);
    tick();

    // I-type: inst[30] honoured only for funct3=101
    fetch(I_SRAI, "srai");
    tick(); #1 chk("srai_alu", 32'(alu), 32'hD);
    tick(); tick();
    fetch(I_ADDI, "addi");
    tick(); #1 chk("addi_alu", 32'(alu), 32'h0);
    tick(); tick();

    // JAL
    fetch(I_JAL, "jal");
    tick(); #1 chk("jal_exe_sel", 32'({imme_sel, rs1_sel}), 32'({3'd4, 2'd1}));
    tick(); #1 chk("jal_wb", 32'(strobes), 32'b0000110);
    chk("jal_wb_sel", 32'({pc_sel, rd_sel}), 32'({2'd1, 2'd2}));
    tick();

    // ack on the last allowed FETCH cycle still succeeds
    tick(); tick(); tick();
    fetch(I_ADD, "late_ack");
    #1 chk("late_ack_dec", 32'({fault, mem_req}), 32'd0);
    tick(); tick(); tick();

    // SW completing, then SW interrupted by reset inside MEM
    fetch(I_SW, "sw");
    tick(); #1 chk("sw_imm", 32'(imme_sel), 32'd1);
    tick(); mem_ack = 1'b1;
    #1 chk("sw_mem_ack", 32'(strobes), 32'b1110100);
    chk("sw_pc_sel", 32'(pc_sel), 32'd0);
    tick(); mem_ack = 1'b0;
    #1 chk("sw_next_fetch", 32'(strobes), 32'b1000000);
    fetch(I_SW, "sw2");
    tick(); tick();
    #1 chk("sw2_mem", 32'(strobes), 32'b1110000);
    #1 rst_n = 1'b0;
    #1 chk("sw2_async_rst", 32'({mem_req, mem_we}), 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("sw2_rel_fetch", 32'({mem_req, mem_sel, mem_we, fault}), 32'b1000);

    // MUL encoding
    tick();
    fetch(I_MUL, "mul");
`ifdef MUL_EN
    tick(); #1 chk("mul_start", 32'(strobes), 32'b0000001);
    tick(); #1 chk("mul_wait", 32'(strobes), 32'd0);
    tick(); tick(); tick(); tick(); mul_done = 1'b1;
    #1 chk("mul_wait5", 32'(strobes), 32'd0);
    tick(); mul_done = 1'b0;
    #1 chk("mul_wb", 32'(strobes), 32'b0000110);
    chk("mul_rd_sel", 32'(rd_sel), 32'd0);
    tick();
`else
    tick(); #1 chk("mul_fault", 32'({fault, strobes}), 32'h80);
    rst_n = 1'b0;
    #1 chk("mul_fault_rst", 32'(fault), 32'd0);
    rst_n = 1'b1;
`endif

    // timeout: four FETCH cycles without ack, then absorbing FAULT
    tick(); tick(); tick();
    #1 chk("to_last_fetch", 32'({fault, mem_req}), 32'b01);
    tick(); #1 chk("to_fault", 32'({fault, strobes}), 32'h80);
    mem_ack = 1'b1; br_taken = 1'b1; mul_done = 1'b1;
    tick(); tick();
    #1 chk("to_fault_hold", 32'({fault, strobes}), 32'h80);
    rst_n = 1'b0;
    #1 chk("to_fault_rst", 32'({fault, strobes}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
